// File: rtl/truth_table_sweeper.sv
// ----------------------------------------------------------------------------
// truth_table_sweeper
//   Exhaustive-stimulus engine for 1-bit combinational checks. It walks all
//   2**N_IN input codes, holds each code for SETTLE_CYC cycles, and then
//   samples dut_out. It builds the observed truth table and counts the codes
//   that differ from a copy of the expected table taken at start.
//
// Build option
//   SWEEP_GRAY_EN : visit the codes in Gray order (idx ^ idx>>1). Only one
//                   input bit changes between vectors, which exposes hazards.
//                   When undefined, the codes are visited in binary ascending
//                   order. Results are indexed by code, so a static DUT gives
//                   identical results in both modes.
//
// Ports
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start, abort    begin sweep (accepted in IDLE only) / cancel sweep
//   expected[DEPTH] expected table, bit i = output for code i
//   dut_out         DUT output under test
//   stim[N_IN]      code driven to the DUT (0 whenever stim_valid=0)
//   stim_valid      stim is meaningful (SETTLE/SAMPLE)
//   busy            sweep in progress (SETTLE/SAMPLE)
//   done            one-cycle pulse when a sweep completes
//   captured        observed table, bit i = dut_out for code i
//   mism_cnt        number of codes where captured != expected
//   pass            last completed sweep had mism_cnt == 0
// ----------------------------------------------------------------------------
module truth_table_sweeper #(
    parameter  int N_IN       = 3,
    parameter  int SETTLE_CYC = 1,
    localparam int DEPTH      = 1 << N_IN,
    localparam int MW         = $clog2(DEPTH + 1),
    localparam int CW         = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [DEPTH-1:0] expected,
    input  logic             dut_out,
    output logic [N_IN-1:0]  stim,
    output logic             stim_valid,
    output logic             busy,
    output logic             done,
    output logic [DEPTH-1:0] captured,
    output logic [MW-1:0]    mism_cnt,
    output logic             pass
);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

    state_t           r_state;
    logic [DEPTH-1:0] r_exp;
    logic [N_IN-1:0]  r_idx;
    logic [CW-1:0]    r_cnt;
    logic [N_IN-1:0]  r_stim;
    logic             r_busy;
    logic             r_done;
    logic [DEPTH-1:0] r_cap;
    logic [MW-1:0]    r_mism;
    logic             r_pass;

    logic [N_IN-1:0]  w_code;
    logic [N_IN-1:0]  w_code_nxt;
    logic             w_last;

    function automatic logic [N_IN-1:0] code_of(input logic [N_IN-1:0] i);
`ifdef SWEEP_GRAY_EN
        return i ^ (i >> 1);
`else
        return i;
`endif
    endfunction

    assign w_code     = code_of(r_idx);
    assign w_code_nxt = code_of(r_idx + 1'b1);
    assign w_last     = (r_idx == N_IN'(DEPTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_exp   <= '0;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_stim  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cap   <= '0;
            r_mism  <= '0;
            r_pass  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // abort wins over a simultaneous start
                    if (start && !abort) begin
                        r_exp   <= expected;
                        r_idx   <= '0;
                        r_stim  <= code_of('0);
                        r_cnt   <= CW'(SETTLE_CYC - 1);
                        r_cap   <= '0;
                        r_mism  <= '0;
                        r_pass  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (abort) begin
                        r_stim  <= '0;
                        r_busy  <= 1'b0;
                        r_pass  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_cnt == '0) begin
                        r_state <= S_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_SAMPLE: begin
                    // An abort skips this cycle's sample. The partial table is kept.
                    if (abort) begin
                        r_stim  <= '0;
                        r_busy  <= 1'b0;
                        r_pass  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cap[w_code] <= dut_out;
                        if (dut_out != r_exp[w_code])
                            r_mism <= r_mism + 1'b1;
                        if (w_last) begin
                            r_stim  <= '0;
                            r_busy  <= 1'b0;
                            r_state <= S_DONE;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_stim  <= w_code_nxt;
                            r_cnt   <= CW'(SETTLE_CYC - 1);
                            r_state <= S_SETTLE;
                        end
                    end
                end
                S_DONE: begin
                    // r_mism already holds the final count here
                    r_done  <= 1'b1;
                    r_pass  <= (r_mism == '0);
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign stim       = r_stim;
    assign stim_valid = r_busy;
    assign busy       = r_busy;
    assign done       = r_done;
    assign captured   = r_cap;
    assign mism_cnt   = r_mism;
    assign pass       = r_pass;

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

    localparam int N_IN   = 3;
    localparam int SETTLE = 1;
    localparam int DEPTH  = 1 << N_IN;
    localparam int MW     = $clog2(DEPTH + 1);
    localparam int S      = SETTLE + 1;
    localparam int DONE_AT = DEPTH * S + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             abort;
    logic [DEPTH-1:0] expected;
    logic             dut_out;
    logic [N_IN-1:0]  stim;
    logic             stim_valid;
    logic             busy;
    logic             done;
    logic [DEPTH-1:0] captured;
    logic [MW-1:0]    mism_cnt;
    logic             pass;

    // The combinational function under test is a lookup table indexed by stim.
    logic [DEPTH-1:0] tbl;
    assign dut_out = tbl[stim];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    truth_table_sweeper #(.N_IN(N_IN), .SETTLE_CYC(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .expected(expected), .dut_out(dut_out), .stim(stim),
        .stim_valid(stim_valid), .busy(busy), .done(done),
        .captured(captured), .mism_cnt(mism_cnt), .pass(pass)
    );

    // Reference model: the order in which the codes are visited
    function automatic int code_ref(input int i);
`ifdef SWEEP_GRAY_EN
        return i ^ (i >> 1);
`else
        return i;
`endif
    endfunction

    function automatic int popcnt(input logic [DEPTH-1:0] v);
        int c = 0;
        for (int i = 0; i < DEPTH; i++) c += int'(v[i]);
        return c;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drives one start and follows the sweep. Returns the number of edges
    // from the accepting edge to the done pulse (200 means timeout). Also
    // returns how many cycles showed a stim or stim_valid value that
    // differs from the model.
    task automatic sweep(input logic [DEPTH-1:0] exp_v, output int cyc, output int terr);
        expected = exp_v;
        start = 1'b1;
        tick;
        start = 1'b0;
        cyc = 0;
        terr = 0;
        for (int k = 0; k < 200; k++) begin
            if (cyc < DEPTH * S) begin
                if (stim_valid !== 1'b1 || stim !== N_IN'(code_ref(cyc / S))) terr++;
            end else begin
                if (stim_valid !== 1'b0 || stim !== '0) terr++;
            end
            tick;
            cyc++;
            if (done === 1'b1) break;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; expected = '0; tbl = '0;
        #12;
        n_cmp++;
        if ({stim, stim_valid, busy, done, captured, mism_cnt, pass} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got stim=%0h v=%b busy=%b done=%b cap=%0h mism=%0d pass=%b, want all 0",
                     stim, stim_valid, busy, done, captured, mism_cnt, pass);
        end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic check_result(input string nm, input int cyc, input int terr,
                                input logic [DEPTH-1:0] exp_v);
        int m = popcnt(tbl ^ exp_v);
        n_cmp++;
        if (cyc !== DONE_AT) begin
            n_err++; $display("FAIL %s_done_cycle: got %0d want %0d", nm, cyc, DONE_AT);
        end
        n_cmp++;
        if (terr !== 0) begin
            n_err++; $display("FAIL %s_stim_trace: got %0d bad cycles want 0", nm, terr);
        end
        n_cmp++;
        if (captured !== tbl) begin
            n_err++; $display("FAIL %s_captured: got %0h want %0h", nm, captured, tbl);
        end
        n_cmp++;
        if (mism_cnt !== MW'(m)) begin
            n_err++; $display("FAIL %s_mism_cnt: got %0d want %0d", nm, mism_cnt, m);
        end
        n_cmp++;
        if (pass !== (m == 0)) begin
            n_err++; $display("FAIL %s_pass: got %b want %b", nm, pass, (m == 0));
        end
        tick;
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL %s_done_pulse_len: got done=%b busy=%b want 0 0", nm, done, busy);
        end
    endtask

    // T1/T2: (x'+y').(y'+z'), with x=stim[2], y=stim[1] and z=stim[0]
    task automatic test_expr;
        int cyc, terr;
        for (int i = 0; i < DEPTH; i++) begin
            logic x, y, z;
            x = i[2]; y = i[1]; z = i[0];
            tbl[i] = (~x | ~y) & (~y | ~z);
        end
        n_cmp++;
        if (tbl !== 8'h37) begin
            n_err++; $display("FAIL expr_table_build: got %0h want 37", tbl);
        end
        sweep(8'b0011_0111, cyc, terr);
        check_result("t1", cyc, terr, 8'b0011_0111);
        sweep(8'b0011_0110, cyc, terr);
        check_result("t2", cyc, terr, 8'b0011_0110);
    endtask

    task automatic test_random;
        int cyc, terr;
        logic [DEPTH-1:0] e;
        for (int n = 0; n < 8; n++) begin
            tbl = DEPTH'($urandom);
            e = (n % 3 == 0) ? tbl : DEPTH'($urandom);
            if (n == 5) e = ~tbl;
            sweep(e, cyc, terr);
            check_result("rand", cyc, terr, e);
        end
    endtask

    task automatic test_abort;
        int cyc, terr, seen;
        tbl = 8'h37;
        expected = 8'h37;
        start = 1'b1; tick; start = 1'b0;
        for (int i = 0; i < 5; i++) tick;
        abort = 1'b1; tick; abort = 1'b0;
        n_cmp++;
        if (stim_valid !== 1'b0 || busy !== 1'b0 || stim !== '0 || pass !== 1'b0) begin
            n_err++; $display("FAIL abort_idle: got v=%b busy=%b stim=%0h pass=%b want 0 0 0 0",
                              stim_valid, busy, stim, pass);
        end
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_err++; $display("FAIL abort_no_done: got %0d active cycles want 0", seen);
        end
        // start together with abort in IDLE: stays idle
        start = 1'b1; abort = 1'b1; tick; start = 1'b0; abort = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL abort_wins_start: got busy=%b want 0", busy);
        end
        sweep(8'h37, cyc, terr);
        check_result("after_abort", cyc, terr, 8'h37);
    endtask

    task automatic test_reset_mid;
        int cyc, terr;
        tbl = 8'h5a;
        expected = 8'h00;
        start = 1'b1; tick; start = 1'b0;
        for (int i = 0; i < 9; i++) tick;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({stim, stim_valid, busy, done, captured, mism_cnt, pass} !== '0) begin
            n_err++; $display("FAIL midreset_async: got stim=%0h v=%b busy=%b done=%b cap=%0h mism=%0d pass=%b want all 0",
                              stim, stim_valid, busy, done, captured, mism_cnt, pass);
        end
        tick; tick;
        rst_n = 1'b1;
        tick;
        sweep(8'h5a, cyc, terr);
        check_result("after_reset", cyc, terr, 8'h5a);
    endtask

    // T5: start held high through the sweep and DONE gives one sweep only
    task automatic test_start_held;
        int cyc, pulses;
        tbl = 8'hc3;
        expected = 8'hc3;
        start = 1'b1;
        tick;
        cyc = 0; pulses = 0;
        for (int k = 0; k < 200; k++) begin
            tick; cyc++;
            if (done === 1'b1) break;
        end
        start = 1'b0;
        if (done === 1'b1) pulses++;
        n_cmp++;
        if (cyc !== DONE_AT) begin
            n_err++; $display("FAIL held_done_cycle: got %0d want %0d", cyc, DONE_AT);
        end
        for (int i = 0; i < 40; i++) begin
            tick;
            if (done === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses !== 1 || busy !== 1'b0) begin
            n_err++; $display("FAIL held_one_sweep: got %0d pulses busy=%b want 1 0", pulses, busy);
        end
    endtask

    // A change to expected in the middle of a sweep must not affect the result.
    task automatic test_expected_change;
        tbl = 8'h96;
        expected = 8'h96;
        start = 1'b1; tick; start = 1'b0;
        tick; tick; tick;
        expected = 8'h69;
        for (int k = 0; k < 200; k++) begin
            tick;
            if (done === 1'b1) break;
        end
        n_cmp++;
        if (mism_cnt !== '0 || pass !== 1'b1) begin
            n_err++; $display("FAIL exp_latched: got mism=%0d pass=%b want 0 1", mism_cnt, pass);
        end
        tick;
    endtask

    initial begin
        test_reset;
        test_expr;
        test_random;
        test_abort;
        test_reset_mid;
        test_start_held;
        test_expected_change;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
